// File: rtl/round_timer_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// game_ctrl_pkg : shared state type, default sizes and width helper for the
//                 round/level sequencer.
// Revision: 1.0
// ---------------------------------------------------------------------------
package game_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    TALLY = 3'd3,
    LOSE  = 3'd4,
    OVER  = 3'd5,
    WIN   = 3'd6
  } round_state_t;

  localparam int c_default_levels = 4;
  localparam int c_default_lives  = 3;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/round_timer_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// round_timer_ctrl_if : game events in, countdown controls and status out.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface round_timer_ctrl_if
  import game_ctrl_pkg::*;
#(
  parameter int LEVELS = c_default_levels
) ();

  logic                           start_key;
  logic                           level_complete;
  logic                           player_hit;
  logic                           finishCount;
  logic                           load;
  logic                           turbo;
  logic                           timer_show;
  logic                           game_active;
  logic [cnt_width(LEVELS)-1:0]   level;
  logic [1:0]                     lives;
  logic                           game_over;
  logic                           game_won;

  // master is the sequencer, slave is the surrounding game/timer logic
  modport master (
    input  start_key, level_complete, player_hit, finishCount,
    output load, turbo, timer_show, game_active, level, lives,
           game_over, game_won
  );

  modport slave (
    output start_key, level_complete, player_hit, finishCount,
    input  load, turbo, timer_show, game_active, level, lives,
           game_over, game_won
  );

endinterface
`default_nettype wire

// File: rtl/round_timer_ctrl_rise_edge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rise_edge : single-flop rising-edge detector with selectable reset value.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rise_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  wire logic clk,
  input  wire logic resetN,
  input  wire logic in,
  output logic      rise
);

  logic r_in_d;

  // Resetting the delay flop high hides a level already held through reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_in_d <= RESET_VAL;
    end else begin
      r_in_d <= in;
    end
  end

  assign rise = in & ~r_in_d;

endmodule
`default_nettype wire

// File: rtl/round_timer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// round_timer_ctrl : Moore round/level sequencer driving the countdown block.
// Revision: 1.0
// ---------------------------------------------------------------------------
module round_timer_ctrl
  import game_ctrl_pkg::*;
#(
  parameter int LEVELS      = c_default_levels,
  parameter int LIVES       = c_default_lives,
  parameter int LOAD_CYCLES = 2,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  wire logic          clk,
  input  wire logic          resetN,
  round_timer_ctrl_if.master bus
);

  localparam int c_level_w = cnt_width(LEVELS);
  localparam int c_load_w  = cnt_width(LOAD_CYCLES);
  localparam int c_hold_w  = cnt_width(HOLD_CYCLES);

  localparam logic [c_level_w-1:0] c_level_max  = c_level_w'(LEVELS - 1);
  localparam logic [1:0]           c_lives_init = 2'(LIVES);
  localparam logic [c_load_w-1:0]  c_load_last  = c_load_w'(LOAD_CYCLES - 1);
  localparam logic [c_hold_w-1:0]  c_hold_last  = c_hold_w'(HOLD_CYCLES - 1);

  round_state_t          r_state;
  round_state_t          w_state_next;
  logic [c_level_w-1:0]  r_level;
  logic [c_level_w-1:0]  w_level_next;
  logic [1:0]            r_lives;
  logic [1:0]            w_lives_next;
  logic [c_load_w-1:0]   r_load_cnt;
  logic [c_load_w-1:0]   w_load_cnt_next;
  logic [c_hold_w-1:0]   r_hold_cnt;
  logic [c_hold_w-1:0]   w_hold_cnt_next;

  logic w_start_rise;
  logic w_load;
  logic w_turbo;
  logic w_timer_show;
  logic w_game_active;
  logic w_game_over;
  logic w_game_won;

  rise_edge #(
    .RESET_VAL (1'b1)
  ) u_start_edge (
    .clk    (clk),
    .resetN (resetN),
    .in     (bus.start_key),
    .rise   (w_start_rise)
  );

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_state    <= IDLE;
      r_level    <= '0;
      r_lives    <= c_lives_init;
      r_load_cnt <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_next;
      r_level    <= w_level_next;
      r_lives    <= w_lives_next;
      r_load_cnt <= w_load_cnt_next;
      r_hold_cnt <= w_hold_cnt_next;
    end
  end

  // Both counters clear whenever their state is not occupied, so every entry
  // into LOAD/OVER/WIN starts from zero without per-transition bookkeeping.
  always_comb begin
    w_state_next    = r_state;
    w_level_next    = r_level;
    w_lives_next    = r_lives;
    w_load_cnt_next = '0;
    w_hold_cnt_next = '0;
    w_load          = 1'b0;
    w_turbo         = 1'b0;
    w_timer_show    = 1'b0;
    w_game_active   = 1'b0;
    w_game_over     = 1'b0;
    w_game_won      = 1'b0;

    case (r_state)
      IDLE: begin
        w_level_next = '0;
        w_lives_next = c_lives_init;
        if (w_start_rise) begin
          w_state_next = LOAD;
        end
      end

      // finishCount is deliberately ignored here: the countdown still shows
      // its stale terminal count until the reload has propagated.
      LOAD: begin
        w_timer_show = 1'b1;
        w_load       = (r_load_cnt == '0);
        if (r_load_cnt == c_load_last) begin
          w_state_next = RUN;
        end else begin
          w_load_cnt_next = r_load_cnt + 1'b1;
        end
      end

      RUN: begin
        w_timer_show  = 1'b1;
        w_game_active = 1'b1;
        if (bus.level_complete) begin
          w_state_next = TALLY;
        end else if (bus.player_hit || bus.finishCount) begin
          w_state_next = LOSE;
        end
      end

      TALLY: begin
        w_timer_show = 1'b1;
        w_turbo      = 1'b1;
        if (bus.finishCount) begin
          if (r_level == c_level_max) begin
            w_state_next = WIN;
          end else begin
            w_level_next = r_level + 1'b1;
            w_state_next = LOAD;
          end
        end
      end

      LOSE: begin
        if (r_lives <= 2'd1) begin
          w_lives_next = 2'd0;
          w_state_next = OVER;
        end else begin
          w_lives_next = r_lives - 2'd1;
          w_state_next = LOAD;
        end
      end

      OVER, WIN: begin
        w_timer_show = 1'b1;
        w_game_over  = (r_state == OVER);
        w_game_won   = (r_state == WIN);
        if (r_hold_cnt == c_hold_last) begin
          w_hold_cnt_next = r_hold_cnt;
          if (w_start_rise) begin
            w_state_next    = IDLE;
            w_level_next    = '0;
            w_lives_next    = c_lives_init;
            w_hold_cnt_next = '0;
          end
        end else begin
          w_hold_cnt_next = r_hold_cnt + 1'b1;
        end
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign bus.load        = w_load;
  assign bus.turbo       = w_turbo;
  assign bus.timer_show  = w_timer_show;
  assign bus.game_active = w_game_active;
  assign bus.level       = r_level;
  assign bus.lives       = r_lives;
  assign bus.game_over   = w_game_over;
  assign bus.game_won    = w_game_won;

endmodule
`default_nettype wire

// File: tb/tb_round_timer_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_round_timer_ctrl : table vectors, corner sequences and random stimulus
//                       for two sequencer instances (4 levels and 2 levels).
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_round_timer_ctrl;

  localparam int LIVES       = 3;
  localparam int LOAD_CYCLES = 2;
  localparam int HOLD        = 16;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  logic sk     = 1'b0;
  logic lc     = 1'b0;
  logic hit    = 1'b0;
  logic fc     = 1'b0;

  always #5 clk = ~clk;

  round_timer_ctrl_if #(.LEVELS(4)) ifa ();
  round_timer_ctrl_if #(.LEVELS(2)) ifb ();

  assign ifa.start_key      = sk;
  assign ifa.level_complete = lc;
  assign ifa.player_hit     = hit;
  assign ifa.finishCount    = fc;
  assign ifb.start_key      = sk;
  assign ifb.level_complete = lc;
  assign ifb.player_hit     = hit;
  assign ifb.finishCount    = fc;

  round_timer_ctrl #(
    .LEVELS(4), .LIVES(LIVES), .LOAD_CYCLES(LOAD_CYCLES), .HOLD_CYCLES(HOLD)
  ) dut_a (.clk(clk), .resetN(resetN), .bus(ifa.master));

  round_timer_ctrl #(
    .LEVELS(2), .LIVES(LIVES), .LOAD_CYCLES(LOAD_CYCLES), .HOLD_CYCLES(HOLD)
  ) dut_b (.clk(clk), .resetN(resetN), .bus(ifb.master));

  int checks = 0;
  int errors = 0;

  // Reference model: phase name, level, lives, cycles spent in LOAD,
  // cycles spent in the end screen, and the last sampled start key.
  string mph  [2];
  int    mlvl [2];
  int    mlv  [2];
  int    mld  [2];
  int    mage [2];
  bit    msd  [2];

  // Output vector: load,turbo,show,active,over,won,lives[1:0],level[1:0]
  function automatic int ev(input int ld, input int tb, input int sh,
                            input int ac, input int ov, input int wn,
                            input int lives, input int lvl);
    return (ld << 9) | (tb << 8) | (sh << 7) | (ac << 6) | (ov << 5) |
           (wn << 4) | (lives << 2) | lvl;
  endfunction

  function automatic int dut_vec(input int m);
    logic [9:0] v;
    if (m == 0)
      v = {ifa.load, ifa.turbo, ifa.timer_show, ifa.game_active,
           ifa.game_over, ifa.game_won, ifa.lives, ifa.level};
    else
      v = {ifb.load, ifb.turbo, ifb.timer_show, ifb.game_active,
           ifb.game_over, ifb.game_won, ifb.lives, 1'b0, ifb.level};
    return int'(v);
  endfunction

  function automatic int mod_vec(input int m);
    string p;
    int ld, sh;
    p  = mph[m];
    ld = (p == "LOAD" && mld[m] == 0) ? 1 : 0;
    sh = (p == "LOAD" || p == "RUN" || p == "TALLY" || p == "OVER" ||
          p == "WIN") ? 1 : 0;
    return ev(ld, (p == "TALLY") ? 1 : 0, sh, (p == "RUN") ? 1 : 0,
              (p == "OVER") ? 1 : 0, (p == "WIN") ? 1 : 0, mlv[m], mlvl[m]);
  endfunction

  task automatic enter_load(input int m);
    mph[m] = "LOAD";
    mld[m] = 0;
  endtask

  task automatic model_step(input int m, input int nlev);
    bit rise;
    rise = sk && !msd[m];
    if (!resetN) begin
      mph[m] = "IDLE"; mlvl[m] = 0; mlv[m] = LIVES;
      mld[m] = 0; mage[m] = 0; msd[m] = 1'b1;
      return;
    end
    msd[m] = sk;
    if (mph[m] == "IDLE") begin
      if (rise) enter_load(m);
    end else if (mph[m] == "LOAD") begin
      mld[m]++;
      if (mld[m] == LOAD_CYCLES) mph[m] = "RUN";
    end else if (mph[m] == "RUN") begin
      if (lc) mph[m] = "TALLY";
      else if (hit || fc) mph[m] = "LOSE";
    end else if (mph[m] == "TALLY") begin
      if (fc) begin
        if (mlvl[m] == nlev - 1) begin
          mph[m] = "WIN"; mage[m] = 1;
        end else begin
          mlvl[m]++; enter_load(m);
        end
      end
    end else if (mph[m] == "LOSE") begin
      if (mlv[m] == 1) begin
        mlv[m] = 0; mph[m] = "OVER"; mage[m] = 1;
      end else begin
        mlv[m]--; enter_load(m);
      end
    end else begin
      if (rise && mage[m] >= HOLD) begin
        mph[m] = "IDLE"; mlvl[m] = 0; mlv[m] = LIVES;
      end else begin
        mage[m]++;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input bit rn, input bit s, input bit l,
                        input bit h, input bit f);
    resetN = rn; sk = s; lc = l; hit = h; fc = f;
  endtask

  // One clock: model consumes the inputs seen at the edge, then both DUTs
  // are compared shortly after the edge.
  task automatic tick();
    @(posedge clk);
    model_step(0, 4);
    model_step(1, 2);
    #1;
    chk("model_a", dut_vec(0), mod_vec(0));
    chk("model_b", dut_vec(1), mod_vec(1));
  endtask

  typedef struct {
    bit rn, s, l, h, f;
    int exp;
  } vec_t;

  vec_t tbl [21];

  initial begin
    tbl[0]  = '{0,0,0,0,0, ev(0,0,0,0,0,0,3,0)};
    tbl[1]  = '{1,0,0,0,0, ev(0,0,0,0,0,0,3,0)};
    tbl[2]  = '{1,1,0,0,0, ev(1,0,1,0,0,0,3,0)};
    tbl[3]  = '{1,1,0,0,0, ev(0,0,1,0,0,0,3,0)};
    tbl[4]  = '{1,0,0,0,0, ev(0,0,1,1,0,0,3,0)};
    tbl[5]  = '{1,0,0,0,1, ev(0,0,0,0,0,0,3,0)};
    tbl[6]  = '{1,0,0,0,1, ev(1,0,1,0,0,0,2,0)};
    tbl[7]  = '{1,0,0,0,1, ev(0,0,1,0,0,0,2,0)};
    tbl[8]  = '{1,0,0,0,0, ev(0,0,1,1,0,0,2,0)};
    tbl[9]  = '{1,0,1,1,0, ev(0,1,1,0,0,0,2,0)};
    tbl[10] = '{1,0,0,0,0, ev(0,1,1,0,0,0,2,0)};
    tbl[11] = '{1,0,0,0,1, ev(1,0,1,0,0,0,2,1)};
    tbl[12] = '{1,0,0,0,0, ev(0,0,1,0,0,0,2,1)};
    tbl[13] = '{1,0,0,0,0, ev(0,0,1,1,0,0,2,1)};
    tbl[14] = '{1,0,0,1,0, ev(0,0,0,0,0,0,2,1)};
    tbl[15] = '{1,0,0,0,0, ev(1,0,1,0,0,0,1,1)};
    tbl[16] = '{1,0,0,0,0, ev(0,0,1,0,0,0,1,1)};
    tbl[17] = '{1,0,0,0,0, ev(0,0,1,1,0,0,1,1)};
    tbl[18] = '{1,0,0,1,0, ev(0,0,0,0,0,0,1,1)};
    tbl[19] = '{1,0,0,0,0, ev(0,0,1,0,1,0,0,1)};
    tbl[20] = '{1,1,0,0,0, ev(0,0,1,0,1,0,0,1)};

    for (int m = 0; m < 2; m++) begin
      mph[m] = "IDLE"; mlvl[m] = 0; mlv[m] = LIVES;
      mld[m] = 0; mage[m] = 0; msd[m] = 1'b1;
    end

    set_in(0, 0, 0, 0, 0);
    for (int i = 0; i < 21; i++) begin
      set_in(tbl[i].rn, tbl[i].s, tbl[i].l, tbl[i].h, tbl[i].f);
      tick();
      chk($sformatf("tbl%0d", i), dut_vec(0), tbl[i].exp);
    end

    // End-screen hold: a rise on the 15th cycle is ignored, the 17th is taken.
    for (int i = 0; i < 13; i++) begin
      set_in(1, 0, 0, 0, 0); tick();
    end
    set_in(1, 1, 0, 0, 0); tick();
    chk("hold_early", int'(ifa.game_over), 1);
    set_in(1, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 0, 0); tick();
    chk("hold_release", dut_vec(0), ev(0,0,0,0,0,0,3,0));

    // Two-level instance finishes both levels.
    set_in(1, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 0, 0); tick();
    set_in(1, 0, 0, 0, 0); tick();
    tick();
    set_in(1, 0, 1, 0, 0); tick();
    set_in(1, 0, 0, 0, 1); tick();
    set_in(1, 0, 0, 0, 0); tick();
    tick();
    set_in(1, 0, 1, 0, 0); tick();
    set_in(1, 0, 0, 0, 1); tick();
    chk("win_b", dut_vec(1), ev(0,0,1,0,0,1,3,1));
    chk("lvl2_a", dut_vec(0), ev(1,0,1,0,0,0,3,2));

    // Start key held across reset release produces no edge.
    set_in(0, 1, 0, 0, 0); tick();
    tick();
    set_in(1, 1, 0, 0, 0); tick();
    chk("held_idle0", dut_vec(0), ev(0,0,0,0,0,0,3,0));
    tick();
    chk("held_idle1", dut_vec(0), ev(0,0,0,0,0,0,3,0));
    set_in(1, 0, 0, 0, 0); tick();
    set_in(1, 1, 0, 0, 0); tick();
    chk("repress_load", int'(ifa.load), 1);

    // Reset asserted while draining in TALLY.
    set_in(1, 0, 0, 0, 0); tick();
    tick();
    set_in(1, 0, 1, 0, 0); tick();
    chk("tally_turbo", int'(ifa.turbo), 1);
    set_in(0, 0, 0, 0, 0); tick();
    chk("rst_tally_a", dut_vec(0), ev(0,0,0,0,0,0,3,0));
    chk("rst_tally_b", dut_vec(1), ev(0,0,0,0,0,0,3,0));

    for (int i = 0; i < 4000; i++) begin
      set_in($urandom_range(0, 299) != 0,
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 14) == 0,
             $urandom_range(0, 5) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
